// File: rtl/aw_arb_pkg.sv
// aw_arb_pkg: shared types and constants for the AW write-address scheduler.
//   aw_arb_state_t  : arbiter FSM states (IDLE arbitrates, GRANT presents AW).
//   GRANT_CNT_WIDTH : width of each per-master grant statistics counter.
package aw_arb_pkg;

  typedef enum logic {IDLE, GRANT} aw_arb_state_t;

  localparam int unsigned GRANT_CNT_WIDTH = 16;

endpackage

// File: rtl/mst_idx_fifo.sv
// mst_idx_fifo: single-clock synchronous FIFO holding granted master indices
// in AW order so the W path can route write data bursts.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i : write an entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   data_o        : head entry, '0 while empty
//   valid_o       : FIFO holds at least one entry
//   full_o        : FIFO holds DEPTH entries
module mst_idx_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/aw_arbiter.sv
// aw_arbiter: round-robin write-address scheduler in front of one slave port.
// Pops the winning master's AW FIFO, presents the beat to the slave with a
// VALID/READY handshake, queues the granted master index for W routing and
// limits outstanding writes until their B responses return.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mst_empty / mst_pop      : per-master AW FIFO status / pop (one-hot or 0)
//   mst_AW*                  : per-master FIFO front fields, master i in slice i
//   AWID..AWBURST, AWVALID   : registered slave-side AW channel
//   AWREADY                  : slave AW ready
//   BVALID, BREADY           : B handshake, retires one outstanding write
//   wq_idx, wq_valid, wq_pop : head of the W-routing queue and its pop
//   grant_cnt                : per-master grant counters
// Optional: define AW_ARB_STATS_EN to build saturating per-master grant
// counters; otherwise grant_cnt is tied to zero.
module aw_arbiter
  import aw_arb_pkg::*;
#(
  parameter int unsigned NUM_MST         = 2,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 4,
  parameter int unsigned SIZE_WIDTH      = 3,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned WQ_DEPTH        = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MST-1:0]                    mst_empty,
  output logic [NUM_MST-1:0]                    mst_pop,
  input  logic [NUM_MST*ID_WIDTH-1:0]           mst_AWID,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]         mst_AWADDR,
  input  logic [NUM_MST*LEN_WIDTH-1:0]          mst_AWLEN,
  input  logic [NUM_MST*SIZE_WIDTH-1:0]         mst_AWSIZE,
  input  logic [NUM_MST*2-1:0]                  mst_AWBURST,
  output logic [ID_WIDTH-1:0]                   AWID,
  output logic [ADDR_WIDTH-1:0]                 AWADDR,
  output logic [LEN_WIDTH-1:0]                  AWLEN,
  output logic [SIZE_WIDTH-1:0]                 AWSIZE,
  output logic [1:0]                            AWBURST,
  output logic                                  AWVALID,
  input  logic                                  AWREADY,
  input  logic                                  BVALID,
  input  logic                                  BREADY,
  output logic [$clog2(NUM_MST)-1:0]            wq_idx,
  output logic                                  wq_valid,
  input  logic                                  wq_pop,
  output logic [NUM_MST*GRANT_CNT_WIDTH-1:0]    grant_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_MST);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  aw_arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      winner_q, winner_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [LEN_WIDTH-1:0]  aw_len_q, aw_len_d;
  logic [SIZE_WIDTH-1:0] aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;

  logic                  wq_full;
  logic                  can_arb;
  logic [NUM_MST-1:0]    eligible;
  logic                  found;
  logic [IDX_W-1:0]      win_idx;
  logic                  aw_hs, b_hs;

  assign AWID    = aw_id_q;
  assign AWADDR  = aw_addr_q;
  assign AWLEN   = aw_len_q;
  assign AWSIZE  = aw_size_q;
  assign AWBURST = aw_burst_q;
  assign AWVALID = (state_q == GRANT);

  assign aw_hs = AWVALID && AWREADY;
  assign b_hs  = BVALID && BREADY;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_MST.
  always_comb begin : rr_search
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    can_arb  = (out_q < OUT_W'(MAX_OUTSTANDING)) && !wq_full;
    eligible = ~mst_empty & {NUM_MST{can_arb}};
    found    = 1'b0;
    win_idx  = '0;
    for (int unsigned k = 0; k < NUM_MST; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NUM_MST;
      cand_idx = IDX_W'(cand);
      if (!found && eligible[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    mst_pop    = '0;
    unique case (state_q)
      IDLE: begin
        // Pop is suppressed while rst is high so no FIFO entry is lost.
        if (found && !rst) begin
          mst_pop[win_idx] = 1'b1;
          winner_d         = win_idx;
          aw_id_d          = mst_AWID[win_idx*ID_WIDTH +: ID_WIDTH];
          aw_addr_d        = mst_AWADDR[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          aw_len_d         = mst_AWLEN[win_idx*LEN_WIDTH +: LEN_WIDTH];
          aw_size_d        = mst_AWSIZE[win_idx*SIZE_WIDTH +: SIZE_WIDTH];
          aw_burst_d       = mst_AWBURST[win_idx*2 +: 2];
          state_d          = GRANT;
        end
      end
      GRANT: begin
        if (AWREADY) begin
          state_d  = IDLE;
          rr_ptr_d = (winner_q == IDX_W'(NUM_MST - 1)) ? '0 : winner_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (aw_hs && !b_hs)                out_d = out_q + OUT_W'(1);
    else if (!aw_hs && b_hs && out_q != '0) out_d = out_q - OUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      out_q      <= '0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      out_q      <= out_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
    end
  end

  mst_idx_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (aw_hs),
    .data_i  (winner_q),
    .pop_i   (wq_pop),
    .data_o  (wq_idx),
    .valid_o (wq_valid),
    .full_o  (wq_full)
  );

`ifdef AW_ARB_STATS_EN
  logic [GRANT_CNT_WIDTH-1:0] cnt_q [NUM_MST];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_MST; i++) cnt_q[i] <= '0;
    end else if (aw_hs && cnt_q[winner_q] != '1) begin
      cnt_q[winner_q] <= cnt_q[winner_q] + GRANT_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_MST; i++)
      grant_cnt[i*GRANT_CNT_WIDTH +: GRANT_CNT_WIDTH] = cnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_aw_arbiter.sv
module tb_aw_arbiter;

  localparam int NM   = 2;
  localparam int IDW  = 4;
  localparam int ADW  = 32;
  localparam int LW   = 4;
  localparam int SW   = 3;
  localparam int MAXO = 8;
  localparam int WQD  = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [ADW-1:0] addr;
    logic [LW-1:0]  len;
    logic [SW-1:0]  size;
    logic [1:0]     burst;
  } req_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     mst_empty;
  logic [NM-1:0]     mst_pop;
  logic [NM*IDW-1:0] mst_AWID;
  logic [NM*ADW-1:0] mst_AWADDR;
  logic [NM*LW-1:0]  mst_AWLEN;
  logic [NM*SW-1:0]  mst_AWSIZE;
  logic [NM*2-1:0]   mst_AWBURST;
  logic [IDW-1:0]    AWID;
  logic [ADW-1:0]    AWADDR;
  logic [LW-1:0]     AWLEN;
  logic [SW-1:0]     AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID, AWREADY, BVALID, BREADY;
  logic [0:0]        wq_idx;
  logic              wq_valid, wq_pop;
  logic [NM*16-1:0]  grant_cnt;

  aw_arbiter #(
    .NUM_MST(NM), .ID_WIDTH(IDW), .ADDR_WIDTH(ADW), .LEN_WIDTH(LW),
    .SIZE_WIDTH(SW), .MAX_OUTSTANDING(MAXO), .WQ_DEPTH(WQD)
  ) dut (
    .clk(clk), .rst(rst), .mst_empty(mst_empty), .mst_pop(mst_pop),
    .mst_AWID(mst_AWID), .mst_AWADDR(mst_AWADDR), .mst_AWLEN(mst_AWLEN),
    .mst_AWSIZE(mst_AWSIZE), .mst_AWBURST(mst_AWBURST),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .BVALID(BVALID), .BREADY(BREADY), .wq_idx(wq_idx), .wq_valid(wq_valid),
    .wq_pop(wq_pop), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending requests per master, the in-flight grant,
  // outstanding count, W-routing order and grant totals.
  req_t mq [NM][$];
  bit   m_pending;
  int   m_cur;
  req_t m_lat;
  int   m_out;
  int   m_wq [$];
  int   m_rr;
  int   m_cnt [NM];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int wlog [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_cur     = 0;
    m_lat     = '0;
    m_out     = 0;
    m_wq.delete();
    m_rr      = 0;
    for (int m = 0; m < NM; m++) m_cnt[m] = 0;
  endtask

  task automatic drive_fronts();
    req_t r;
    for (int m = 0; m < NM; m++) begin
      mst_empty[m] = (mq[m].size() == 0);
      r = (mq[m].size() > 0) ? mq[m][0] : '0;
      mst_AWID[m*IDW +: IDW]    = r.id;
      mst_AWADDR[m*ADW +: ADW]  = r.addr;
      mst_AWLEN[m*LW +: LW]     = r.len;
      mst_AWSIZE[m*SW +: SW]    = r.size;
      mst_AWBURST[m*2 +: 2]     = r.burst;
    end
  endtask

  task automatic load(input int m, input int n);
    req_t r;
    repeat (n) begin
      r.id    = IDW'($urandom);
      r.addr  = $urandom;
      r.len   = LW'($urandom);
      r.size  = SW'($urandom);
      r.burst = 2'($urandom);
      mq[m].push_back(r);
    end
    drive_fronts();
  endtask

  // One clock: compare at the negedge, advance the model at the posedge.
  task automatic cycle();
    int          win;
    int          c;
    logic [NM-1:0]    exp_pop;
    logic [NM*16-1:0] exp_cnt;
    bit          aw, b;
    @(negedge clk);
    win     = -1;
    exp_pop = '0;
    if (!rst && !m_pending && m_out < MAXO && m_wq.size() < WQD)
      for (int k = 0; k < NM; k++) begin
        c = (m_rr + k) % NM;
        if (win < 0 && mq[c].size() > 0) win = c;
      end
    if (win >= 0) exp_pop[win] = 1'b1;
    exp_cnt = '0;
`ifdef AW_ARB_STATS_EN
    for (int m = 0; m < NM; m++) exp_cnt[m*16 +: 16] = 16'(m_cnt[m]);
`endif
    chk("mst_pop",   mst_pop,  exp_pop);
    chk("AWVALID",   AWVALID,  m_pending);
    chk("AWID",      AWID,     m_lat.id);
    chk("AWADDR",    AWADDR,   m_lat.addr);
    chk("AWLEN",     AWLEN,    m_lat.len);
    chk("AWSIZE",    AWSIZE,   m_lat.size);
    chk("AWBURST",   AWBURST,  m_lat.burst);
    chk("wq_valid",  wq_valid, m_wq.size() > 0);
    chk("wq_idx",    wq_idx,   (m_wq.size() > 0) ? m_wq[0] : 0);
    chk("grant_cnt", grant_cnt, exp_cnt);
    if (AWVALID && AWREADY && !rst) hs_cnt++;
    if (wq_valid && wq_pop && !rst) wlog.push_back(int'(wq_idx));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      aw = m_pending && AWREADY;
      b  = BVALID && BREADY;
      if (wq_pop && m_wq.size() > 0) void'(m_wq.pop_front());
      if (aw) begin
        m_wq.push_back(m_cur);
        m_rr = (m_cur + 1) % NM;
        if (m_cnt[m_cur] < 65535) m_cnt[m_cur]++;
        m_pending = 0;
      end
      if (aw && !b) m_out++;
      else if (!aw && b && m_out > 0) m_out--;
      if (win >= 0) begin
        m_lat     = mq[win].pop_front();
        m_cur     = win;
        m_pending = 1;
      end
    end
    #1;
    drive_fronts();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; AWREADY = 1'b0; BVALID = 1'b0; BREADY = 1'b0; wq_pop = 1'b0;
    model_reset();
    drive_fronts();
    repeat (2) @(posedge clk);
    #1;
    cycle();                      // reset state checked with rst still high
    rst = 1'b0;

    // wq_pop with an empty queue changes nothing
    wq_pop = 1'b1;
    repeat (2) cycle();

    // Both masters busy, B follows every AW: alternating grants
    AWREADY = 1'b1; BVALID = 1'b1; BREADY = 1'b1; wq_pop = 1'b1;
    wlog.delete();
    load(0, 4); load(1, 4);
    cycle();
    chk("aw_latency", AWVALID, 1'b1);
    repeat (20) cycle();
    chk("wlog_len", wlog.size(), 8);
    for (int i = 0; i < wlog.size(); i++) chk("wlog_order", wlog[i], i % 2);

    // Slave stalls five cycles during GRANT
    AWREADY = 1'b0;
    load(1, 1);
    cycle();
    hs_cnt = 0;
    repeat (5) cycle();
    AWREADY = 1'b1;
    cycle();
    chk("stall_single_hs", hs_cnt, 1);
    repeat (3) cycle();

    // Outstanding cap: 9 requests, no B responses
    BVALID = 1'b0;
    load(0, 9);
    hs_cnt = 0;
    repeat (30) cycle();
    chk("cap_hs", hs_cnt, 8);
    BVALID = 1'b1;
    cycle();
    BVALID = 1'b0;
    repeat (5) cycle();
    chk("cap_release", hs_cnt, 9);
    BVALID = 1'b1;
    repeat (12) cycle();

    // W-routing queue full blocks arbitration
    wq_pop = 1'b0;
    load(0, 3); load(1, 3);
    hs_cnt = 0;
    repeat (20) cycle();
    chk("wq_full_hs", hs_cnt, 4);
    wq_pop = 1'b1;
    cycle();
    wq_pop = 1'b0;
    repeat (4) cycle();
    chk("wq_pop_release", hs_cnt, 5);
    wq_pop = 1'b1;
    repeat (15) cycle();

    // Simultaneous AW and B handshakes with three outstanding
    BVALID = 1'b0;
    load(1, 3);
    repeat (10) cycle();
    load(0, 1);
    cycle();
    BVALID = 1'b1;
    cycle();
    BVALID = 1'b0;
    load(0, 10);
    hs_cnt = 0;
    repeat (30) cycle();
    chk("simul_cap_hs", hs_cnt, 5);
    BVALID = 1'b1;
    repeat (25) cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      AWREADY = ($urandom_range(0, 3) != 0);
      BVALID  = ($urandom_range(0, 2) != 0);
      BREADY  = ($urandom_range(0, 3) != 0);
      wq_pop  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int m;
        m = int'($urandom_range(0, NM - 1));
        if (mq[m].size() < 3) load(m, 1);
      end
      cycle();
    end
    AWREADY = 1'b1; BVALID = 1'b1; BREADY = 1'b1; wq_pop = 1'b1;
    repeat (40) cycle();

    // Reset while a grant is being presented
    AWREADY = 1'b0;
    load(1, 1); load(0, 1);
    cycle();
    chk("pre_rst_awvalid", AWVALID, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_awvalid",   AWVALID,   1'b0);
    chk("rst_wq_valid",  wq_valid,  1'b0);
    chk("rst_grant_cnt", grant_cnt, '0);
    load(0, 2); load(1, 2);
    AWREADY = 1'b1;
    repeat (14) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aw_arbiter.md
Name: aw_arbiter

Overview:
- Single-clock write-address scheduler in front of one slave port of the crossbar.
- Round-robin arbitrates among NUM_MST write-address FIFO front ends and pops the winner.
- Drives the winning AW beat to the slave with a VALID/READY handshake.
- Records the granted master index in an in-order W-routing queue and caps outstanding write transactions until their B responses return.

Parameters:
- NUM_MST, 2, number of requesting masters (≥2).
- ID_WIDTH, 4, AWID width.
- ADDR_WIDTH, 32, AWADDR width.
- LEN_WIDTH, 4, AWLEN width.
- SIZE_WIDTH, 3, AWSIZE width.
- MAX_OUTSTANDING, 8, maximum accepted AWs without a B handshake.
- WQ_DEPTH, 4, depth of the W-routing queue (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mst_empty  in  NUM_MST  per-master AW FIFO empty.
- mst_pop  out  NUM_MST  per-master AW FIFO pop, one-hot or zero.
- mst_AWID  in  NUM_MST*ID_WIDTH  FIFO fronts; master i in slice i.
- mst_AWADDR  in  NUM_MST*ADDR_WIDTH  as above.
- mst_AWLEN  in  NUM_MST*LEN_WIDTH  as above.
- mst_AWSIZE  in  NUM_MST*SIZE_WIDTH  as above.
- mst_AWBURST  in  NUM_MST*2  as above.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  param widths  registered slave-side AW fields.
- AWVALID  out  1  slave AW valid.
- AWREADY  in  1  slave AW ready.
- BVALID  in  1  slave B valid.
- BREADY  in  1  B ready from the response path.
- wq_idx  out  $clog2(NUM_MST)  master index of the oldest un-routed write.
- wq_valid  out  1  wq_idx is valid.
- wq_pop  in  1  W path finished that burst (WLAST handshake).
- grant_cnt  out  NUM_MST*16  per-master grant counters (see Optional Feature).

Behaviour:
- Reset (rst sampled high at posedge):
  - state=IDLE; AWVALID=0; AW field registers=0; mst_pop=0.
  - rr_ptr=0; outstanding=0; W-routing queue emptied (wq_valid=0, wq_idx=0).
  - Reset mid-grant drops AWVALID immediately; the already-popped entry is discarded.
- FSM state IDLE:
  - eligible = ~mst_empty & {NUM_MST{outstanding<MAX_OUTSTANDING && !wq_full}}.
  - If eligible is nonzero, the winner is the first eligible index searching rr_ptr, rr_ptr+1, … modulo NUM_MST.
  - mst_pop[winner]=1 combinationally in that cycle; the winner's front fields are latched into the AW registers; winner is latched; next state=GRANT.
- FSM state GRANT:
  - AWVALID=1; fields held stable; mst_pop=0.
  - On AWVALID&&AWREADY: push winner into the W-routing queue, outstanding+=1, rr_ptr=(winner+1) mod NUM_MST, next state=IDLE.
  - No re-arbitration in the handshake cycle. Peak throughput is 1 AW per 2 cycles; latency is 1 cycle from non-empty to AWVALID.
- Outstanding counter ($clog2(MAX_OUTSTANDING+1) bits):
  - +1 on AW handshake; -1 on BVALID&&BREADY.
  - Both in the same cycle: unchanged.
  - B handshake at 0: held at 0, no underflow.
  - At MAX_OUTSTANDING no new arbitration occurs; a current GRANT still completes.
- W-routing queue (sync FIFO, WQ_DEPTH entries):
  - wq_idx/wq_valid show the head entry.
  - wq_pop while empty is ignored.
  - Push and pop in the same cycle are both performed; count unchanged.
  - Pointers wrap modulo WQ_DEPTH.
  - wq_full blocks arbitration, so an overflowing push is impossible.
- Only one mst_pop bit may ever be high, and only in IDLE.

Optional Feature:
- Macro AW_ARB_STATS_EN.
- Defined: grant_cnt slice i increments on each AW handshake for master i, saturates at 16'hFFFF, and is cleared by rst.
- Undefined: grant_cnt is tied to 0 and no counter flops are present.

Decomposition:
- Package aw_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} aw_arb_state_t;
  - GRANT_CNT_WIDTH=16.
- Sub-module mst_idx_fifo: a parameterised single-clock sync FIFO (width $clog2(NUM_MST), depth WQ_DEPTH) for the W-routing queue.
- The round-robin search stays inline.

Test Plan:
- Both masters non-empty from reset, AWREADY=1, BREADY=BVALID held so B follows each AW:
  - grants alternate 0,1,0,1;
  - AWVALID first rises on cycle 2 after the fronts are presented;
  - wq_idx sequence 0,1,0,1.
- AWREADY=0 for 5 cycles during GRANT:
  - AWVALID and fields stay stable;
  - no mst_pop;
  - single handshake on the cycle AWREADY rises.
- Master 0 only, BVALID=0, 9 requests:
  - exactly 8 handshakes;
  - AWVALID stays low while outstanding=8;
  - one B handshake releases the 9th AW.
- wq_pop never asserted, 4 grants:
  - wq full; arbitration stalls despite outstanding<8;
  - one wq_pop allows the next grant.
- Simultaneous AW handshake and B handshake with outstanding=3: stays 3. wq_pop with wq empty: no change.
- rst pulsed during GRANT:
  - AWVALID=0 the next cycle;
  - outstanding=0, wq_valid=0, rr_ptr=0;
  - with AW_ARB_STATS_EN defined, grant_cnt=0.
